// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: EX-stage issue, stall and writeback controller for the RV32M mul_div unit
module muldiv_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic [31:0]     id_instr_i,
    input  logic [XLEN-1:0] id_rs1_val_i,
    input  logic [XLEN-1:0] id_rs2_val_i,
    input  logic            flush_i,
    output logic            ex_stall_o,
    output logic            md_start_o,
    output logic [2:0]      md_opcode_o,
    output logic [XLEN-1:0] md_rs1_o,
    output logic [XLEN-1:0] md_rs2_o,
    input  logic            md_busy_i,
    input  logic            md_ready_i,
    input  logic [XLEN-1:0] md_result_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            md_timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DRAIN} state_t;

    state_t          state_q;
    logic [CW-1:0]   wdog_q;
    logic            start_q;
    logic            wb_q;
    logic            timeout_q;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] wb_data_q;
    logic            is_m;
    logic            m_op;
    logic            cand;
    logic            wdog_hit;
    logic            unused_ok;

    // Operand register fields are not needed here and the unit's busy flag is only
    // observed externally; the controller tracks occupancy through its own state.
    assign unused_ok = ^{id_instr_i[24:15], md_busy_i};

    assign is_m     = (id_instr_i[6:0] == 7'b0110011) && (id_instr_i[31:25] == 7'b0000001);
    assign m_op     = id_valid_i && is_m && (id_instr_i[11:7] != 5'd0);
    assign cand     = m_op && !flush_i;
    assign wdog_hit = (wdog_q == CW'(TIMEOUT - 1)) && !md_ready_i;

    // Issue FSM: launch, wait for the result, write back, or drain a killed op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wdog_q    <= '0;
            start_q   <= 1'b0;
            wb_q      <= 1'b0;
            timeout_q <= 1'b0;
            op_q      <= '0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            wb_data_q <= '0;
        end else begin
            start_q <= 1'b0;
            wb_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cand) begin
                        op_q    <= id_instr_i[14:12];
                        rd_q    <= id_instr_i[11:7];
                        rs1_q   <= id_rs1_val_i;
                        rs2_q   <= id_rs2_val_i;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= flush_i ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (md_ready_i && !flush_i) begin
                        wb_data_q <= md_result_i;
                        wb_rd_q   <= rd_q;
                        wb_q      <= 1'b1;
                        state_q   <= WB;
                    end else if (md_ready_i) begin
                        state_q <= IDLE;
                    end else if (flush_i) begin
                        wdog_q  <= '0;
                        state_q <= DRAIN;
                    end else if (wdog_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                DRAIN: begin
                    if (md_ready_i) begin
                        state_q <= IDLE;
                    end else if (wdog_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall: hold upstream while an op occupies the unit; release in WB so the
    // completing instruction retires on the same edge.
    always_comb begin
        ex_stall_o = (state_q == IDLE)  ? cand :
                     (state_q == ISSUE) ? 1'b1 :
                     (state_q == WAIT)  ? 1'b1 :
                     (state_q == DRAIN) ? m_op : 1'b0;
    end

    assign md_start_o   = start_q;
    assign md_opcode_o  = op_q;
    assign md_rs1_o     = rs1_q;
    assign md_rs2_o     = rs2_q;
    assign wb_valid_o   = wb_q && !flush_i;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign md_timeout_o = timeout_q;
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: vector table plus corner sequences against a behavioural mul_div stand-in
module tb_muldiv_issue_ctrl;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic        m;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] id_instr = '0;
    logic [31:0] id_rs1 = '0;
    logic [31:0] id_rs2 = '0;
    logic        ex_stall, md_start, wb_valid, md_timeout;
    logic [2:0]  md_opcode;
    logic [31:0] md_rs1, md_rs2, wb_data;
    logic [4:0]  wb_rd;
    logic        md_busy = 1'b0;
    logic        md_ready = 1'b0;
    logic [31:0] md_result = '0;

    int          total = 0;
    int          bad = 0;
    int          n_start = 0;
    int          lat = 1;
    int          cnt = 0;
    bit          hang = 1'b0;
    logic [2:0]  exp_f3 = '0;
    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    logic [36:0] sb[$];
    logic        prev_wb = 1'b0;
    logic        prev_start = 1'b0;

    muldiv_issue_ctrl #(.XLEN(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_instr_i(id_instr),
        .id_rs1_val_i(id_rs1), .id_rs2_val_i(id_rs2), .flush_i(flush),
        .ex_stall_o(ex_stall), .md_start_o(md_start), .md_opcode_o(md_opcode),
        .md_rs1_o(md_rs1), .md_rs2_o(md_rs2),
        .md_busy_i(md_busy), .md_ready_i(md_ready), .md_result_i(md_result),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .md_timeout_o(md_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb6, ua, ub, p;
        logic signed [31:0] x, y, q;
        sa  = {{32{a[31]}}, a};
        sb6 = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        x   = a;
        y   = b;
        case (op)
            3'd0: begin p = sa * sb6; return p[31:0]; end
            3'd1: begin p = sa * sb6; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                q = x / y;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = x % y;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ex_stall"}, ex_stall, 0);
        chk({tag, "_md_start"}, md_start, 0);
        chk({tag, "_md_opcode"}, md_opcode, 0);
        chk({tag, "_md_rs1"}, md_rs1, 0);
        chk({tag, "_md_rs2"}, md_rs2, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_md_timeout"}, md_timeout, 0);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b, input int l);
        id_valid = 1'b1;
        id_instr = instr;
        id_rs1   = a;
        id_rs2   = b;
        lat      = l;
        exp_f3   = instr[14:12];
        exp_a    = a;
        exp_b    = b;
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = md_start;
        end
        chk({name, "_start_seen"}, seen, 1);
    endtask

    task automatic wait_retire(input string name, output int st);
        bit done = 1'b0;
        st = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (ex_stall) st++;
            else done = 1'b1;
        end
        chk({name, "_retired"}, done, 1);
        @(posedge clk); #1;
        id_valid = 1'b0;
    endtask

    task automatic run(input vec_t v, input int idx);
        int st;
        int s0 = n_start;
        string nm = $sformatf("vec%0d", idx);
        drive(v.instr, v.a, v.b, v.lat);
        if (v.m) sb.push_back({v.instr[11:7], v.exp});
        wait_retire(nm, st);
        chk({nm, "_stall_cycles"}, st, v.m ? v.lat + 2 : 0);
        chk({nm, "_starts"}, n_start - s0, v.m ? 1 : 0);
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    // Behavioural mul_div: result appears lat cycles after the start pulse.
    always @(posedge clk) begin
        md_ready <= 1'b0;
        if (rst) begin
            md_busy <= 1'b0;
            cnt     <= 0;
        end else if (md_start) begin
            md_result <= alu(md_opcode, md_rs1, md_rs2);
            if (lat <= 1) begin
                md_ready <= !hang;
                md_busy  <= hang;
            end else begin
                md_busy <= 1'b1;
                cnt     <= lat - 1;
            end
        end else if (md_busy && !hang) begin
            if (cnt == 1) begin
                md_busy  <= 1'b0;
                md_ready <= 1'b1;
            end
            cnt <= cnt - 1;
        end
    end

    // Launch checks and writeback scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (md_start) begin
                n_start++;
                chk("start_while_busy", md_busy, 0);
                chk("start_pulse_width", prev_start, 0);
                chk("md_opcode", md_opcode, exp_f3);
                chk("md_rs1", md_rs1, exp_a);
                chk("md_rs2", md_rs2, exp_b);
            end
            if (wb_valid) begin
                chk("wb_back_to_back", prev_wb, 0);
                if (sb.size() == 0) begin
                    chk("wb_unexpected", wb_valid, 0);
                end else begin
                    logic [36:0] e;
                    e = sb.pop_front();
                    chk("wb_rd", wb_rd, e[36:32]);
                    chk("wb_data", wb_data, e[31:0]);
                end
            end
        end
        prev_start = md_start;
        prev_wb    = wb_valid;
    end

    initial begin
        vec_t tbl[11];
        int   st;
        int   s0;
        int   n;
        tbl[0]  = '{32'h022082B3, 32'd15, 32'd10, 3, 1'b1, 32'd150};
        tbl[1]  = '{32'h0241C333, 32'd7, 32'd0, 5, 1'b1, 32'hFFFFFFFF};
        tbl[2]  = '{enc(3'd7, 5'd7), 32'hFFFFFFFF, 32'd10, 2, 1'b1, 32'd5};
        tbl[3]  = '{32'h02208033, 32'd15, 32'd10, 3, 1'b0, 32'd0};
        tbl[4]  = '{enc(3'd3, 5'd8), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b1, 32'hFFFFFFFE};
        tbl[5]  = '{enc(3'd1, 5'd9), 32'h80000000, 32'h80000000, 4, 1'b1, 32'h40000000};
        tbl[6]  = '{enc(3'd4, 5'd10), 32'h80000000, 32'hFFFFFFFF, 6, 1'b1, 32'h80000000};
        tbl[7]  = '{enc(3'd6, 5'd11), 32'hFFFFFFF9, 32'd3, 2, 1'b1, 32'hFFFFFFFF};
        tbl[8]  = '{enc(3'd5, 5'd12), 32'd100, 32'd7, 1, 1'b1, 32'd14};
        tbl[9]  = '{enc(3'd2, 5'd13), 32'hFFFFFFFF, 32'd2, 3, 1'b1, 32'hFFFFFFFF};
        tbl[10] = '{32'h002082B3, 32'd1, 32'd2, 1, 1'b0, 32'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i], i);

        // Flush in WAIT of DIVU 100/7, MUL presented right behind it.
        drive(enc(3'd5, 5'd12), 32'd100, 32'd7, 8);
        wait_start("flush");
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drive(32'h022082B3, 32'd15, 32'd10, 3);
        sb.push_back({5'd5, 32'd150});
        wait_retire("flush_mul", st);
        chk("flush_stall_cycles", st, 11);
        chk("flush_sb_empty", sb.size(), 0);

        // Reset mid-WAIT drops the in-flight REMU.
        drive(enc(3'd7, 5'd7), 32'd33, 32'd4, 10);
        wait_start("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        id_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk); #1;
        run('{32'h022082B3, 32'hFFFFFFF9, 32'd3, 2, 1'b1, 32'hFFFFFFEB}, 99);

        // Watchdog: unit never answers.
        hang = 1'b1;
        s0 = n_start;
        drive(32'h022082B3, 32'd15, 32'd10, 3);
        wait_start("wdog");
        @(posedge clk); #1;
        id_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 200 && !md_timeout; c++) begin
            @(negedge clk);
            if (!md_timeout) n++;
        end
        chk("wdog_wait_cycles", n, 64);
        chk("wdog_idle_stall", ex_stall, 0);
        repeat (5) @(negedge clk);
        chk("wdog_sticky", md_timeout, 1);
        chk("wdog_starts", n_start - s0, 1);
        chk("wdog_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        rst  = 1'b1;
        hang = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("wdog_cleared", md_timeout, 0);

        @(posedge clk); #1;
        run(tbl[0], 100);
        repeat (3) @(posedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
